// File: rtl/bp_update_arbiter_pkg.sv
// Shared branch-info layout, branch type codes and reset polarity for the
// branch-predictor update path.
package bp_update_arbiter_pkg;

  localparam int SIZE_OF_BRANCH_INFO = 67;

  // Record layout, MSB first: pc | taken | target | type
  localparam int BRANCH_INFO_PC_HI     = 66;
  localparam int BRANCH_INFO_PC_LO     = 35;
  localparam int BRANCH_INFO_TAKEN     = 34;
  localparam int BRANCH_INFO_TARGET_HI = 33;
  localparam int BRANCH_INFO_TARGET_LO = 2;
  localparam int BRANCH_INFO_TYP_HI    = 1;
  localparam int BRANCH_INFO_TYP_LO    = 0;

  localparam logic [1:0] BTYPE_COND = 2'd0;
  localparam logic [1:0] BTYPE_JUMP = 2'd1;
  localparam logic [1:0] BTYPE_CALL = 2'd2;
  localparam logic [1:0] BTYPE_RET  = 2'd3;

  localparam logic RstEnable = 1'b1;

  function automatic logic [SIZE_OF_BRANCH_INFO-1:0] make_branch_info(
    input logic [31:0] pc,
    input logic        taken,
    input logic [31:0] target,
    input logic [1:0]  typ
  );
    return {pc, taken, target, typ};
  endfunction

endpackage

// File: rtl/bp_upd_fifo2w1r.sv
// In-order circular buffer accepting up to two records per cycle and
// releasing one; slot 0 is always written first.
module bp_upd_fifo2w1r
  import bp_update_arbiter_pkg::*;
#(
  parameter  int INFO_W = SIZE_OF_BRANCH_INFO,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en0,
  input  logic [INFO_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [INFO_W-1:0] wr_data1,
  input  logic              rd_en,
  output logic [INFO_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [INFO_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [1:0]        n_wr;

  assign n_wr = {1'b0, wr_en0} + {1'b0, wr_en1};

  // Storage is deliberately left unreset; the empty gate on head_data hides it.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_ptr] <= wr_data0;
    if (wr_en1) mem[wr_ptr + PTR_W'(1)] <= wr_data1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_wr);
      rd_ptr <= rd_ptr + PTR_W'(rd_en);
      count  <= count + CNT_W'(n_wr) - CNT_W'(rd_en);
    end
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/bp_update_arbiter.sv
// Serialises dual-slot branch resolutions onto the predictor's single update
// port. Optional same-cycle bypass of an empty queue: BP_UPD_BYPASS_EN.
module bp_update_arbiter
  import bp_update_arbiter_pkg::*;
#(
  parameter  int INFO_W = SIZE_OF_BRANCH_INFO,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid0,
  input  logic [INFO_W-1:0] in_info0,
  input  logic              in_valid1,
  input  logic [INFO_W-1:0] in_info1,
  output logic              in_ready,
  input  logic              flush,
  output logic              upd_valid,
  output logic [INFO_W-1:0] upd_info,
  input  logic              upd_ready,
  output logic [PTR_W:0]    occupancy
);

  logic [CNT_W-1:0]  count;
  logic [INFO_W-1:0] head_data;
  logic              fifo_nonempty;
  logic              accept;
  logic              bypass_hit;
  logic              bypass_take;
  logic              wr_en0;
  logic              wr_en1;
  logic [INFO_W-1:0] wr_data0;
  logic [INFO_W-1:0] wr_data1;

  assign fifo_nonempty = (count != '0);
  // Registered count only, so a same-cycle dequeue never frees space here.
  assign in_ready      = (count <= CNT_W'(DEPTH - 2));
  assign accept        = in_ready & ~flush;
  assign occupancy     = count;

`ifdef BP_UPD_BYPASS_EN
  assign bypass_hit  = ~fifo_nonempty & ~flush & (in_valid0 | in_valid1);
  assign bypass_take = bypass_hit & upd_ready;
  assign upd_valid   = fifo_nonempty | bypass_hit;
  assign upd_info    = fifo_nonempty ? head_data :
                       bypass_hit    ? (in_valid0 ? in_info0 : in_info1) : '0;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
  assign upd_valid   = fifo_nonempty;
  assign upd_info    = head_data;
`endif

  // Compact the valid slots so the buffer always sees its writes from port 0 up.
  always_comb begin
    wr_en0   = 1'b0;
    wr_en1   = 1'b0;
    wr_data0 = in_info0;
    wr_data1 = in_info1;
    if (accept) begin
      if (bypass_take) begin
        if (in_valid0 && in_valid1) begin
          wr_en0   = 1'b1;
          wr_data0 = in_info1;
        end
      end else if (in_valid0 && in_valid1) begin
        wr_en0 = 1'b1;
        wr_en1 = 1'b1;
      end else if (in_valid0) begin
        wr_en0 = 1'b1;
      end else if (in_valid1) begin
        wr_en0   = 1'b1;
        wr_data0 = in_info1;
      end
    end
  end

  bp_upd_fifo2w1r #(
    .INFO_W (INFO_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .wr_en0    (wr_en0),
    .wr_data0  (wr_data0),
    .wr_en1    (wr_en1),
    .wr_data1  (wr_data1),
    .rd_en     (fifo_nonempty & upd_ready),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Bench for bp_update_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_bp_update_arbiter;
  import bp_update_arbiter_pkg::*;

  localparam int W     = SIZE_OF_BRANCH_INFO;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid0, in_valid1, in_ready, flush;
  logic [W-1:0]  in_info0, in_info1, upd_info;
  logic          upd_valid, upd_ready;
  logic [2:0]    occupancy;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] model_q[$];

  bp_update_arbiter #(.INFO_W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid0 (in_valid0),
    .in_info0  (in_info0),
    .in_valid1 (in_valid1),
    .in_info1  (in_info1),
    .in_ready  (in_ready),
    .flush     (flush),
    .upd_valid (upd_valid),
    .upd_info  (upd_info),
    .upd_ready (upd_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rec(input logic [31:0] pc);
    return {pc, 1'b1, pc + 32'h40, BTYPE_COND};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model
  // by what the coming edge must do.
  task automatic applyStimulus(input string name, input logic v0, input logic [W-1:0] i0,
                               input logic v1, input logic [W-1:0] i1,
                               input logic rdy, input logic fl);
    logic         exp_ready, exp_valid, byp, skip;
    logic [W-1:0] exp_info;
    int           n;
    @(negedge clk);
    in_valid0 = v0; in_info0 = i0; in_valid1 = v1; in_info1 = i1;
    upd_ready = rdy; flush = fl;
    #1;
    n         = model_q.size();
    exp_ready = (DEPTH - n) >= 2;
    byp       = 1'b0;
`ifdef BP_UPD_BYPASS_EN
    byp = (n == 0) && !fl && (v0 || v1);
`endif
    exp_valid = (n != 0) || byp;
    exp_info  = (n != 0) ? model_q[0] : byp ? (v0 ? i0 : i1) : '0;
    checkOutput({name, ".in_ready"},  W'(in_ready),  W'(exp_ready));
    checkOutput({name, ".upd_valid"}, W'(upd_valid), W'(exp_valid));
    checkOutput({name, ".upd_info"},  upd_info,      exp_info);
    checkOutput({name, ".occupancy"}, W'(occupancy), W'(n));
    if (fl) begin
      model_q.delete();
    end else begin
      if (n != 0 && rdy) void'(model_q.pop_front());
      if (exp_ready) begin
        skip = byp && rdy;
        if (v0) begin if (skip) skip = 1'b0; else model_q.push_back(i0); end
        if (v1) begin if (skip) skip = 1'b0; else model_q.push_back(i1); end
      end
    end
  endtask

  task automatic idle(input string name, input logic rdy);
    applyStimulus(name, 1'b0, '0, 1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; upd_ready = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_info0 = '0; in_info1 = '0;
    #1;
    checkOutput("reset.upd_valid", W'(upd_valid), '0);
    checkOutput("reset.occupancy", W'(occupancy), '0);
    checkOutput("reset.in_ready",  W'(in_ready),  W'(1));
    checkOutput("reset.upd_info",  upd_info,      '0);
    @(negedge clk); rst = 1'b0;
    idle("idle", 1'b1);

    $display("[TB] pair in order");
    applyStimulus("pair", 1'b1, rec(32'h1000), 1'b1, rec(32'h1004), 1'b1, 1'b0);
    idle("pair_d1", 1'b1);
    idle("pair_d2", 1'b1);
    idle("pair_d3", 1'b1);

    $display("[TB] slot1 alone");
    applyStimulus("slot1", 1'b0, rec(32'hDEAD), 1'b1, rec(32'h2008), 1'b1, 1'b0);
    idle("slot1_d1", 1'b1);
    idle("slot1_d2", 1'b1);

    $display("[TB] backpressure fill and drain");
    applyStimulus("fill0", 1'b1, rec(32'h4000), 1'b1, rec(32'h4004), 1'b0, 1'b0);
    applyStimulus("fill1", 1'b1, rec(32'h4008), 1'b1, rec(32'h400C), 1'b0, 1'b0);
    applyStimulus("fill2", 1'b1, rec(32'h4010), 1'b1, rec(32'h4014), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) idle($sformatf("drain%0d", k), 1'b1);

    $display("[TB] flush with pending handshake");
    applyStimulus("fl_a", 1'b1, rec(32'h5000), 1'b1, rec(32'h5004), 1'b0, 1'b0);
    applyStimulus("fl_b", 1'b1, rec(32'h5008), 1'b0, '0, 1'b0, 1'b0);
    applyStimulus("fl_c", 1'b1, rec(32'h5100), 1'b1, rec(32'h5104), 1'b1, 1'b1);
    idle("fl_after", 1'b1);

    $display("[TB] empty queue, slot0 with ready");
    applyStimulus("byp", 1'b1, rec(32'h3000), 1'b0, '0, 1'b1, 1'b0);
    idle("byp_d1", 1'b1);
    idle("byp_d2", 1'b1);

    $display("[TB] asynchronous reset with three entries");
    applyStimulus("ar_a", 1'b1, rec(32'h6000), 1'b1, rec(32'h6004), 1'b0, 1'b0);
    applyStimulus("ar_b", 1'b1, rec(32'h6008), 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid0 = 1'b0; in_valid1 = 1'b0; upd_ready = 1'b0;
    #1;
    checkOutput("ar.occ_before", W'(occupancy), W'(3));
    #1 rst = 1'b1;
    #1;
    checkOutput("ar.occupancy", W'(occupancy), '0);
    checkOutput("ar.upd_valid", W'(upd_valid), '0);
    #1 rst = 1'b0;
    model_q.delete();
    idle("ar_after", 1'b1);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      logic [W-1:0] r0, r1;
      r0 = {32'($urandom()), 32'($urandom()), 3'($urandom())};
      r1 = {32'($urandom()), 32'($urandom()), 3'($urandom())};
      applyStimulus($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), r0,
                    1'($urandom_range(0, 1)), r1,
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
